// File: rtl/ritc_vcdl_scan.sv
// VCDL phase scan: steps the clock phase shifter, accumulates feedback hits per
// step over a sync window and records the first step where the level flips.
module ritc_vcdl_scan #(
   parameter int NSTEPS     = 56,
   parameter int WINDOW     = 64,
   parameter int PS_TIMEOUT = 1023
) (
   input  logic       sysclk_i,
   input  logic       rst_n_i,
   input  logic       sync_i,
   input  logic       vcdl_fb_q_i,
   input  logic       start_i,
   output logic       ps_en_o,
   input  logic       ps_done_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic       edge_found_o,
   output logic [7:0] edge_step_o,
   output logic [7:0] count_o
);

   localparam int SW = $clog2(WINDOW + 1);
   localparam int TW = $clog2(PS_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ACCUM, STEP, WAIT_PS, DONE} state_t;

   state_t        state_q, state_d;
   logic          busy_q;
   logic [7:0]    step_q, step_d;
   logic [SW-1:0] sample_q, sample_d, hit_q, hit_d;
   logic [SW-1:0] sample_inc, hit_inc;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          prev_level_q, prev_level_d;
   logic          error_q, error_d;
   logic          edge_found_q, edge_found_d;
   logic [7:0]    edge_step_q, edge_step_d;
   logic [7:0]    count_q, count_d;
   logic          start_ok, sync_hit, win_full, level, last_step, tmo_hit;

   assign start_ok   = (state_q == IDLE) && start_i;
   assign sync_hit   = (state_q == ACCUM) && sync_i;
   assign sample_inc = sample_q + SW'(1);
   assign hit_inc    = hit_q + SW'(vcdl_fb_q_i);
   // The sync that fills the window is evaluated together with its own hit.
   assign win_full   = sync_hit && (sample_inc == SW'(WINDOW));
   assign level      = (hit_inc >= SW'(WINDOW / 2));
   assign last_step  = (step_q == 8'(NSTEPS - 1));
   assign tmo_hit    = (state_q == WAIT_PS) && !ps_done_i && (tmo_q == TW'(PS_TIMEOUT - 1));

   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = ACCUM;
         ACCUM:   if (win_full) state_d = last_step ? DONE : STEP;
         STEP:    state_d = WAIT_PS;
         WAIT_PS: begin
            if (ps_done_i)    state_d = ACCUM;
            else if (tmo_hit) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ps_en_o      = (state_q == STEP);
      done_o       = (state_q == DONE);
      busy_o       = busy_q;
      error_o      = error_q;
      edge_found_o = edge_found_q;
      edge_step_o  = edge_step_q;
      count_o      = count_q;
   end

   always_comb begin
      step_d       = step_q;
      sample_d     = sample_q;
      hit_d        = hit_q;
      tmo_d        = tmo_q;
      prev_level_d = prev_level_q;
      error_d      = error_q;
      edge_found_d = edge_found_q;
      edge_step_d  = edge_step_q;
      count_d      = count_q;
      if (start_ok) begin
         step_d       = '0;
         sample_d     = '0;
         hit_d        = '0;
         edge_found_d = 1'b0;
         edge_step_d  = '0;
         error_d      = 1'b0;
      end
      if (sync_hit) begin
         sample_d = sample_inc;
         hit_d    = hit_inc;
      end
      if (win_full) begin
         count_d      = 8'(hit_inc);
         prev_level_d = level;
         if ((step_q != 8'd0) && (level != prev_level_q) && !edge_found_q) begin
            edge_found_d = 1'b1;
            edge_step_d  = step_q;
         end
      end
      if (state_q == STEP) tmo_d = '0;
      if (state_q == WAIT_PS) begin
         tmo_d = tmo_q + TW'(1);
         if (ps_done_i) begin
            step_d   = step_q + 8'd1;
            sample_d = '0;
            hit_d    = '0;
         end else if (tmo_hit) begin
            error_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         step_q       <= '0;
         sample_q     <= '0;
         hit_q        <= '0;
         tmo_q        <= '0;
         prev_level_q <= 1'b0;
         error_q      <= 1'b0;
         edge_found_q <= 1'b0;
         edge_step_q  <= '0;
         count_q      <= '0;
      end else begin
         step_q       <= step_d;
         sample_q     <= sample_d;
         hit_q        <= hit_d;
         tmo_q        <= tmo_d;
         prev_level_q <= prev_level_d;
         error_q      <= error_d;
         edge_found_q <= edge_found_d;
         edge_step_q  <= edge_step_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_ritc_vcdl_scan.sv
// Randomized bench for ritc_vcdl_scan: each scan's hits per step are tallied and
// the expected edge/count/error/pulse counts derived from the scan rules.
module tb_ritc_vcdl_scan;

   localparam int NS = 8;
   localparam int W  = 4;
   localparam int PT = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sync = 1'b0, fb = 1'b0, start = 1'b0, ps_done = 1'b0;
   logic       ps_en, busy, done, err, ef;
   logic [7:0] es, cnt;

   int total = 0;
   int bad = 0;
   int ps_en_seen = 0;
   int done_seen = 0;
   int scan_no = 0;

   always #5 clk = ~clk;

   ritc_vcdl_scan #(.NSTEPS(NS), .WINDOW(W), .PS_TIMEOUT(PT)) dut (
      .sysclk_i(clk), .rst_n_i(rst_n), .sync_i(sync), .vcdl_fb_q_i(fb),
      .start_i(start), .ps_en_o(ps_en), .ps_done_i(ps_done), .busy_o(busy),
      .done_o(done), .error_o(err), .edge_found_o(ef), .edge_step_o(es),
      .count_o(cnt)
   );

   always @(negedge clk) begin
      if (ps_en) ps_en_seen++;
      if (done) done_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL scan=%0d %s got=%0d exp=%0d", scan_no, tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic f, input logic st, input logic pd);
      sync = s; fb = f; start = st; ps_done = pd;
      tick();
      sync = 1'b0; start = 1'b0; ps_done = 1'b0;
   endtask

   // Non-counted cycle: sync/ps_done/start may toggle wherever they must be ignored.
   task automatic junk(input logic allow_sync, input logic allow_pd);
      drive(allow_sync & ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), allow_pd & ($urandom_range(0, 2) == 0));
   endtask

   function automatic logic gen_fb(input int mode, input int s, input int k);
      case (mode)
         1:       return (s >= 3);
         2:       return 1'b1;
         3:       return (s == 0) ? (k < 2) : (s == 5);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic run_scan(input int mode, input int tmo_after, input int abort_step);
      int  hits[NS];
      int  pe0, d0, last, d, exp_es;
      logic exp_ef, timed_out, f;
      scan_no++;
      pe0 = ps_en_seen; d0 = done_seen; last = 0; timed_out = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("busy_after_start", busy, 1);
      chk("error_cleared", err, 0);
      chk("edge_found_cleared", ef, 0);
      for (int s = 0; s < NS; s++) begin
         hits[s] = 0;
         for (int k = 0; k < W; k++) begin
            repeat ($urandom_range(0, 2)) junk(1'b0, 1'b1);
            if (s == abort_step && k == 2) begin
               chk("count_before_reset", cnt, hits[s-1]);
               #2 rst_n = 1'b0;
               #1;
               chk("outputs_in_reset", {busy, done, ps_en, err, ef, es, cnt}, 0);
               repeat (2) @(posedge clk);
               #1;
               chk("outputs_held_reset", {busy, done, ps_en, err, ef, es, cnt}, 0);
               chk("no_done_on_abort", done_seen - d0, 0);
               rst_n = 1'b1;
               $display("scan %0d aborted by reset at step %0d", scan_no, s);
               return;
            end
            f = gen_fb(mode, s, k);
            hits[s] += int'(f);
            drive(1'b1, f, 1'b0, 1'b0);
         end
         last = s;
         if (s == NS - 1) break;
         chk("ps_en_pulse", ps_en, 1);
         if (s == tmo_after) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            repeat (PT - 1) junk(1'b1, 1'b0);
            chk("done_before_timeout", done, 0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            timed_out = 1'b1;
            break;
         end
         d = ($urandom_range(0, 3) == 0) ? PT - 1 : $urandom_range(0, 5);
         junk(1'b1, 1'b1);
         chk("ps_en_one_cycle", ps_en, 0);
         repeat (d) junk(1'b1, 1'b0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);

      exp_ef = 1'b0; exp_es = 0;
      for (int s = 1; s <= last; s++)
         if (!exp_ef && ((hits[s] >= W / 2) != (hits[s-1] >= W / 2))) begin
            exp_ef = 1'b1;
            exp_es = s;
         end
      chk("edge_found", ef, exp_ef);
      chk("edge_step", es, exp_es);
      chk("count", cnt, hits[last]);
      chk("error", err, timed_out);
      chk("ps_en_total", ps_en_seen - pe0, timed_out ? last + 1 : last);
      chk("done_total", done_seen - d0, 1);
      $display("scan %0d mode=%0d last_step=%0d edge=%0d@%0d count=%0d error=%0d",
               scan_no, mode, last, ef, es, cnt, err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, ps_en, err, ef, es, cnt}, 0);
      rst_n = 1'b1;
      run_scan(1, -1, -1);
      run_scan(2, -1, -1);
      run_scan(3, -1, -1);
      run_scan(0, 1, -1);
      run_scan(0, -1, -1);
      run_scan(1, -1, 4);
      run_scan(1, -1, -1);
      for (int i = 0; i < 8; i++)
         run_scan(0, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NS - 2)) : -1, -1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ritc_vcdl_scan.md
RITC_VCDL_SCAN -- requirements
Module: RITC_vcdl_scan

Interface
REQ-001 SHALL have parameter NSTEPS, default 56: number of phase steps scanned (2..255).
REQ-002 SHALL have parameter WINDOW, default 64: sync samples accumulated per step (power of 2, 2..128).
REQ-003 SHALL have parameter PS_TIMEOUT, default 1023: sysclk cycles allowed for phase-step completion.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all logic on sysclk_i.
REQ-005 sysclk_i  in  1  system clock.
REQ-006 rst_n_i  in  1  asynchronous active-low reset.
REQ-007 sync_i  in  1  one-cycle strobe per sync period; the sample point.
REQ-008 vcdl_fb_q_i  in  1  VCDL feedback bit, already captured by the phase-shifted clock and retimed to sysclk_i.
REQ-009 start_i  in  1  one-cycle scan request.
REQ-010 ps_en_o  out  1  one-cycle phase-step request to the clock phase shifter.
REQ-011 ps_done_i  in  1  phase-step complete strobe.
REQ-012 busy_o  out  1  scan in progress.
REQ-013 done_o  out  1  one-cycle scan-finished strobe.
REQ-014 error_o  out  1  sticky phase-step timeout flag; cleared by next accepted start_i.
REQ-015 edge_found_o  out  1  level transition detected during last scan.
REQ-016 edge_step_o  out  8  step index of the first transition.
REQ-017 count_o  out  8  hit count of the most recently completed window.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, STEP, WAIT_PS, DONE.
REQ-019 IDLE: start_i -> ACCUM, clear step, sample_cnt, hit_cnt, edge_found_o, edge_step_o, error_o; start_i ignored in every other state.
REQ-020 ACCUM: each sync_i increments sample_cnt and, if vcdl_fb_q_i=1 in the same cycle, hit_cnt; cycles without sync_i change nothing.
REQ-021 The sync_i that brings sample_cnt to WINDOW SHALL be counted, and evaluation SHALL use the updated hit_cnt in that same cycle.
REQ-022 Evaluation: level = (hit_cnt >= WINDOW/2); count_o <= hit_cnt; if step>0, level != prev_level and edge_found_o=0, then edge_found_o<=1, edge_step_o<=step; prev_level<=level.
REQ-023 After evaluation: step = NSTEPS-1 -> DONE, else -> STEP.
REQ-024 STEP: ps_en_o=1 for exactly one cycle, then WAIT_PS with timeout counter cleared.
REQ-025 WAIT_PS: ps_done_i -> step+1, clear sample_cnt and hit_cnt, -> ACCUM; ps_done_i outside WAIT_PS SHALL be ignored; sync_i in WAIT_PS SHALL NOT be counted.
REQ-026 WAIT_PS: timeout counter reaching PS_TIMEOUT with no ps_done_i -> error_o<=1, -> DONE; ps_done_i in the timeout cycle wins (no error).
REQ-027 DONE: done_o=1 for one cycle, -> IDLE.
REQ-028 busy_o SHALL be 1 in all states except IDLE, registered (asserted the cycle after start_i).
REQ-029 Only the first transition SHALL be recorded; later transitions leave edge_step_o unchanged.
REQ-030 Counters SHALL be sized to hold WINDOW and PS_TIMEOUT without wrap.

Reset
REQ-031 rst_n_i low SHALL immediately force IDLE and all outputs, counters and prev_level to 0, including mid-scan.
REQ-032 After rst_n_i deasserts, the first start_i SHALL be accepted on the next rising edge.

Verification (bench: NSTEPS=8, WINDOW=4, PS_TIMEOUT=15)
REQ-033 fb=0 for steps 0-2, 1 for steps 3-7, ps_done_i 3 cycles after each ps_en_o -> 7 ps_en_o pulses, done_o once, edge_found_o=1, edge_step_o=3, count_o=4.
REQ-034 fb constant 1 throughout -> edge_found_o=0, count_o=4, error_o=0, 7 ps_en_o pulses.
REQ-035 Fb pattern 1,1,0,0 per window at step 0 then all 0 -> step-0 level=1 (2>=2), transition at step 1, edge_step_o=1; extra transition at step 5 ignored.
REQ-036 ps_done_i withheld after the 2nd ps_en_o -> error_o=1 after 15 cycles, done_o once, busy_o=0 next cycle; next start_i clears error_o.
REQ-037 rst_n_i pulsed low during step 4 ACCUM -> all outputs 0 asynchronously; no done_o; subsequent start_i runs a full scan.
REQ-038 start_i repeated while busy_o=1 and ps_done_i pulsed during STEP -> no restart, no step advance, scan results unchanged.
